// File: rtl/alu_pipelined_if.sv
// Request/response bundle between the EX-stage issue logic and alu_pipelined.
interface alu_pipelined_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALU_operand_1;
  logic [WIDTH-1:0] ALU_operand_2;
  logic [3:0]       ALU_ctrl_input;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_result;
  logic [WIDTH-1:0] ALU_result_hi;
  logic             Zero;
  logic             Overflow;
  logic             Illegal;

  // Issuing side: drives requests and consumes results.
  modport master (
    output in_valid, ALU_operand_1, ALU_operand_2, ALU_ctrl_input, out_ready,
    input  in_ready, out_valid, ALU_result, ALU_result_hi, Zero, Overflow, Illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, ALU_operand_1, ALU_operand_2, ALU_ctrl_input, out_ready,
    output in_ready, out_valid, ALU_result, ALU_result_hi, Zero, Overflow, Illegal
  );
endinterface

// File: rtl/alu_pipelined.sv
// Registered MIPS-style ALU with valid/ready handshake and an iterative
// shift-add unsigned multiply producing a double-width result.
module alu_pipelined #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  alu_pipelined_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    mul_a;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mul_b;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             ready_c;
  logic             accept_c;
  logic             is_mul_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_ill_c;

  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             zero_q;
  logic             ovf_q;
  logic             ill_q;

  assign a  = bus.ALU_operand_1;
  assign b  = bus.ALU_operand_2;
  assign op = bus.ALU_ctrl_input;

  // Accept only when idle and the output register is free or draining.
  assign ready_c  = rst_n && (state == IDLE) && (!valid_q || bus.out_ready);
  assign accept_c = bus.in_valid && ready_c;
  assign is_mul_c = MUL_EN && (op == OP_MULU);

  assign sum_c  = a + b;
  assign diff_c = a - b;

  // Single-cycle result, overflow and illegal-opcode decode.
  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    alu_ill_c = 1'b0;
    case (op)
      OP_AND: alu_res_c = a & b;
      OP_OR:  alu_res_c = a | b;
      OP_XOR: alu_res_c = a ^ b;
      OP_NOR: alu_res_c = ~(a | b);
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      // True signed compare, independent of A-B overflow.
      OP_SLT: alu_res_c = WIDTH'($signed(a) < $signed(b));
      OP_MULU: alu_ill_c = !MUL_EN;
      default: alu_ill_c = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept_c && is_mul_c) state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == CNT_W'(1)) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shift-add multiply datapath: one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept_c && is_mul_c) begin
      mul_a <= PW'(a);
      mul_b <= b;
      acc   <= '0;
      cnt   <= CNT_W'(WIDTH);
    end else if (state == MUL_RUN) begin
      if (mul_b[0]) acc <= acc + mul_a;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // Output register: load on single-cycle accept or multiply completion, else hold/drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (accept_c && !is_mul_c) begin
      valid_q  <= 1'b1;
      res_q    <= alu_res_c;
      res_hi_q <= '0;
      zero_q   <= (alu_res_c == '0);
      ovf_q    <= alu_ovf_c;
      ill_q    <= alu_ill_c;
    end else if (state == MUL_DONE) begin
      valid_q  <= 1'b1;
      res_q    <= acc[WIDTH-1:0];
      res_hi_q <= acc[PW-1:WIDTH];
      zero_q   <= (acc[WIDTH-1:0] == '0);
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready      = ready_c;
  assign bus.out_valid     = valid_q;
  assign bus.ALU_result    = res_q;
  assign bus.ALU_result_hi = res_hi_q;
  assign bus.Zero          = zero_q;
  assign bus.Overflow      = ovf_q;
  assign bus.Illegal       = ill_q;

endmodule

// File: tb/tb_alu_pipelined.sv
// Bench for alu_pipelined: arithmetic model + scoreboard on the MUL_EN=1
// instance, directed literal checks on both instances.
module tb_alu_pipelined;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         ovf;
    logic         ill;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   run = 0;
  int   max_run = 0;
  res_t q[$];

  always #5 clk = ~clk;

  alu_pipelined_if #(.WIDTH(W)) bus_a ();
  alu_pipelined_if #(.WIDTH(W)) bus_b ();

  alu_pipelined #(.WIDTH(W), .MUL_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  alu_pipelined #(.WIDTH(W), .MUL_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the opcode table.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit mul_en);
    int ua, ub, sa, sb, r;
    res_t m;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    m = '0;
    case (op)
      4'b0000: m.lo = a & b;
      4'b0001: m.lo = a | b;
      4'b0011: m.lo = a ^ b;
      4'b1100: m.lo = ~(a | b);
      4'b0010: begin
        r = sa + sb;
        m.lo = W'(ua + ub);
        m.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      end
      4'b0110: begin
        r = sa - sb;
        m.lo = W'(ua - ub);
        m.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      end
      4'b0111: m.lo = (sa < sb) ? W'(1) : W'(0);
      4'b1000: begin
        if (mul_en) begin
          r = ua * ub;
          m.lo = W'(r);
          m.hi = W'(r >> W);
        end else begin
          m.ill = 1'b1;
        end
      end
      default: m.ill = 1'b1;
    endcase
    m.zero = (m.lo == '0);
    return m;
  endfunction

  function automatic res_t dut_out(input bit sel);
    res_t r;
    if (sel) r = '{bus_b.ALU_result_hi, bus_b.ALU_result, bus_b.Zero, bus_b.Overflow, bus_b.Illegal};
    else     r = '{bus_a.ALU_result_hi, bus_a.ALU_result, bus_a.Zero, bus_a.Overflow, bus_a.Illegal};
    return r;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  function automatic logic ov(input bit sel);
    return sel ? bus_b.out_valid : bus_a.out_valid;
  endfunction

  // Scoreboard on instance A: results in accept order, compared whenever valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      run = 0;
    end else begin
      if (bus_a.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'(bus_a.out_valid), 64'd0);
        end else begin
          check("scoreboard", 64'(dut_out(1'b0)), 64'(q[0]));
          if (bus_a.out_ready) void'(q.pop_front());
        end
      end else begin
        run = 0;
      end
      if (bus_a.in_valid && bus_a.in_ready)
        q.push_back(model(bus_a.ALU_ctrl_input, bus_a.ALU_operand_1, bus_a.ALU_operand_2, 1'b1));
    end
  end

  task automatic set_req(input bit sel, input bit v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel) begin
      bus_b.in_valid = v; bus_b.ALU_ctrl_input = op;
      bus_b.ALU_operand_1 = a; bus_b.ALU_operand_2 = b;
    end else begin
      bus_a.in_valid = v; bus_a.ALU_ctrl_input = op;
      bus_a.ALU_operand_1 = a; bus_a.ALU_operand_2 = b;
    end
  endtask

  // Present a request and hold it until it is accepted; returns #1 after the accept edge.
  task automatic issue(input bit sel, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    set_req(sel, 1'b1, op, a, b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin ok = 1'b1; break; end
    end
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    set_req(sel, 1'b0, op, a, b);
  endtask

  // Count negedges until out_valid; also note whether in_ready stayed low meanwhile.
  task automatic wait_out(input bit sel, output int n, output bit rdy_low);
    n = 0;
    rdy_low = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (ov(sel)) break;
      if (rdy(sel)) rdy_low = 1'b0;
      if (n >= 40) begin
        check("out_valid_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic expect_out(input bit sel, input string name, input logic [W-1:0] lo,
                            input logic [W-1:0] hi, input logic z, input logic o, input logic il);
    res_t e;
    e = '{hi, lo, z, o, il};
    check(name, 64'(dut_out(sel)), 64'(e));
  endtask

  task automatic run_op(input bit sel, input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] lo,
                        input logic [W-1:0] hi, input logic z, input logic o, input logic il);
    int n;
    bit rl;
    issue(sel, op, a, b);
    wait_out(sel, n, rl);
    expect_out(sel, name, lo, hi, z, o, il);
  endtask

  initial begin
    int n;
    bit rl;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 4'b0000, '0, '0);
    set_req(1'b1, 1'b0, 4'b0000, '0, '0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    #2;
    expect_out(1'b0, "reset_outputs", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus_a.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(bus_a.in_ready), 64'd1);

    // ADD latency and basic results
    issue(1'b0, 4'b0010, 8'd15, 8'd10);
    wait_out(1'b0, n, rl);
    check("add_valid_on_accept_edge", 64'(n), 64'd1);
    expect_out(1'b0, "add_15_10", 8'd25, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "sub_10_10", 4'b0110, 8'd10, 8'd10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, "add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, "sub_ovf", 4'b0110, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, "and", 4'b0000, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "or",  4'b0001, 8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "nor", 4'b1100, 8'hF0, 8'h3C, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "xor", 4'b0011, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "slt_m3_2", 4'b0111, 8'hFD, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "slt_2_m3", 4'b0111, 8'h02, 8'hFD, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, "slt_80_7f", 4'b0111, 8'h80, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);

    // MULU timing and result
    issue(1'b0, 4'b1000, 8'd200, 8'd3);
    wait_out(1'b0, n, rl);
    check("mulu_valid_edges_after_accept", 64'(n - 1), 64'(W + 1));
    check("mulu_in_ready_low", 64'(rl), 64'd1);
    expect_out(1'b0, "mulu_200_3", 8'h58, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, "mulu_0_5", 4'b1000, 8'd0, 8'd5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, "mulu_ff_ff", 4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);

    // MUL_EN=0 instance: MULU decodes as illegal, single-cycle
    issue(1'b1, 4'b1000, 8'd12, 8'd3);
    wait_out(1'b1, n, rl);
    check("nomul_valid_on_accept_edge", 64'(n), 64'd1);
    expect_out(1'b1, "nomul_illegal", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold result 3 cycles with a queued request waiting
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    issue(1'b0, 4'b0010, 8'd5, 8'd6);
    set_req(1'b0, 1'b1, 4'b0110, 8'd20, 8'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
      check("bp_out_valid_held", 64'(bus_a.out_valid), 64'd1);
      expect_out(1'b0, "bp_result_held", 8'd11, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_on_drain", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 4'b0000, '0, '0);
    @(negedge clk);
    check("bp_next_valid", 64'(bus_a.out_valid), 64'd1);
    expect_out(1'b0, "bp_next_sub", 8'd17, 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-to-back throughput
    repeat (2) @(negedge clk);
    max_run = 0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0010, 8'd1, 8'd2);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0011, 8'hAA, 8'h55);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0111, 8'h7F, 8'h80);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0001, 8'h00, 8'h00);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 4'b0000, '0, '0);
    repeat (3) @(negedge clk);
    check("b2b_consecutive_valid", 64'(max_run), 64'd4);

    // Asynchronous reset in the middle of a multiply
    run_op(1'b0, "pre_reset_add", 4'b0010, 8'd15, 8'd10, 8'd25, 8'h00, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 4'b1000, 8'd7, 8'd9);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_out(1'b0, "async_reset_outputs", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("async_reset_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("async_reset_in_ready", 64'(bus_a.in_ready), 64'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) n++;
    end
    check("no_valid_after_abort", 64'(n), 64'd0);

    run_op(1'b0, "illegal_1111", 4'b1111, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
